// File: rtl/aud_i2s_pkg.sv
// Shared constants, slot map and state encoding for the codec-side I2S master.
package aud_i2s_pkg;

   localparam int unsigned SAMPLE_W    = 16;
   localparam int unsigned SLOT_W      = 32;
   localparam int unsigned FRAME_SLOTS = 64;
   localparam int unsigned SLOT_CNT_W  = $clog2(FRAME_SLOTS);

   typedef logic [SLOT_CNT_W-1:0] slot_t;

   // Data sits one slot after each LRCK edge (I2S one-bit delay).
   localparam slot_t SLOT_L_FIRST = slot_t'(1);
   localparam slot_t SLOT_L_LAST  = slot_t'(SAMPLE_W);
   localparam slot_t SLOT_R_FIRST = slot_t'(SLOT_W + 1);
   localparam slot_t SLOT_R_LAST  = slot_t'(SLOT_W + SAMPLE_W);
   localparam slot_t SLOT_LAST    = slot_t'(FRAME_SLOTS - 1);

   typedef enum logic {S_IDLE, S_RUN} state_t;

   function automatic logic in_left(input slot_t s);
      return (s >= SLOT_L_FIRST) && (s <= SLOT_L_LAST);
   endfunction

   function automatic logic in_right(input slot_t s);
      return (s >= SLOT_R_FIRST) && (s <= SLOT_R_LAST);
   endfunction

endpackage

// File: rtl/aud_i2s_clkgen.sv
// BCLK divider, LRCK and slot counter with rise/fall/frame-start strobes.
module aud_i2s_clkgen
   import aud_i2s_pkg::*;
#(
   parameter int unsigned BCLK_HALF = 2
) (
   input  logic  clk,
   input  logic  rst_n,
   input  logic  en,
   output logic  bclk,
   output logic  lrck,
   output slot_t slot,
   output logic  rise,
   output logic  fall,
   output logic  frame_start,
   output logic  clear
);

   localparam int unsigned       DIV_W    = (BCLK_HALF > 1) ? $clog2(BCLK_HALF) : 1;
   localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(BCLK_HALF - 1);

   state_t           state, state_nxt;
   logic             count;
   logic             tick;
   logic [DIV_W-1:0] div;
   slot_t            slot_nxt;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) state <= S_IDLE;
      else        state <= state_nxt;
   end

   // Counting starts in the very cycle enable is first seen so the first
   // BCLK rise lands BCLK_HALF cycles later.
   always_comb begin
      state_nxt = state;
      count     = 1'b0;
      clear     = 1'b0;
      case (state)
         S_IDLE: begin
            if (en) begin
               state_nxt = S_RUN;
               count     = 1'b1;
            end
         end
         S_RUN: begin
            if (en) begin
               count = 1'b1;
            end else begin
               state_nxt = S_IDLE;
               clear     = 1'b1;
            end
         end
         default: state_nxt = S_IDLE;
      endcase
   end

   assign tick        = count && (div == DIV_LAST);
   assign rise        = tick && !bclk;
   assign fall        = tick && bclk;
   assign frame_start = fall && (slot == SLOT_LAST);
   assign slot_nxt    = slot + slot_t'(1);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         div  <= '0;
         bclk <= 1'b0;
         slot <= SLOT_LAST;
         lrck <= 1'b1;
      end else if (clear) begin
         div  <= '0;
         bclk <= 1'b0;
         slot <= SLOT_LAST;
         lrck <= 1'b1;
      end else if (count) begin
         if (tick) begin
            div  <= '0;
            bclk <= ~bclk;
            if (bclk) begin
               slot <= slot_nxt;
               lrck <= slot_nxt[SLOT_CNT_W-1];
            end
         end else begin
            div <= div + DIV_W'(1);
         end
      end
   end

endmodule

// File: rtl/aud_i2s_codec_master.sv
// Codec-side I2S master: ADC holding register + serializer, DAC deserializer.
module aud_i2s_codec_master
   import aud_i2s_pkg::*;
#(
   parameter int unsigned BCLK_HALF = 2
) (
   input  logic                i_clk,
   input  logic                i_rst_n,
   input  logic                i_en,
   input  logic [SAMPLE_W-1:0] i_adc_l,
   input  logic [SAMPLE_W-1:0] i_adc_r,
   input  logic                i_adc_valid,
   output logic                o_adc_ready,
   output logic                o_underrun,
   output logic [SAMPLE_W-1:0] o_dac_l,
   output logic [SAMPLE_W-1:0] o_dac_r,
   output logic                o_dac_valid,
   output logic                o_bclk,
   output logic                o_lrck,
   output logic                o_adcdat,
   input  logic                i_dacdat
);

   logic                hold_full;
   logic [SAMPLE_W-1:0] hold_l, hold_r;
   logic [SAMPLE_W-1:0] tx_l, tx_r;
   logic [SAMPLE_W-2:0] rx_sh;
   logic [SAMPLE_W-1:0] rx_l_stage;
   logic [SAMPLE_W-1:0] rx_word;
   logic                accept;
   logic                rise, fall, frame_start, clear;
   slot_t               slot, slot_nxt;

   aud_i2s_clkgen #(
      .BCLK_HALF (BCLK_HALF)
   ) u_clkgen (
      .clk         (i_clk),
      .rst_n       (i_rst_n),
      .en          (i_en),
      .bclk        (o_bclk),
      .lrck        (o_lrck),
      .slot        (slot),
      .rise        (rise),
      .fall        (fall),
      .frame_start (frame_start),
      .clear       (clear)
   );

   assign o_adc_ready = !hold_full;
   assign accept      = i_adc_valid && !hold_full;
   assign slot_nxt    = slot + slot_t'(1);
   assign rx_word     = {rx_sh, i_dacdat};

   // A pair accepted in an empty-holding frame-start cycle survives to the next frame.
   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         hold_full  <= 1'b0;
         hold_l     <= '0;
         hold_r     <= '0;
         tx_l       <= '0;
         tx_r       <= '0;
         o_adcdat   <= 1'b0;
         o_underrun <= 1'b0;
      end else begin
         o_underrun <= 1'b0;
         if (accept) begin
            hold_l    <= i_adc_l;
            hold_r    <= i_adc_r;
            hold_full <= 1'b1;
         end
         if (clear) begin
            tx_l     <= '0;
            tx_r     <= '0;
            o_adcdat <= 1'b0;
         end else if (fall) begin
            if (frame_start) begin
               if (hold_full) begin
                  tx_l      <= hold_l;
                  tx_r      <= hold_r;
                  hold_full <= 1'b0;
               end else begin
                  tx_l       <= '0;
                  tx_r       <= '0;
                  o_underrun <= 1'b1;
               end
               o_adcdat <= 1'b0;
            end else if (in_left(slot_nxt)) begin
               o_adcdat <= tx_l[SAMPLE_W-1];
               tx_l     <= {tx_l[SAMPLE_W-2:0], 1'b0};
            end else if (in_right(slot_nxt)) begin
               o_adcdat <= tx_r[SAMPLE_W-1];
               tx_r     <= {tx_r[SAMPLE_W-2:0], 1'b0};
            end else begin
               o_adcdat <= 1'b0;
            end
         end
      end
   end

   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         rx_sh       <= '0;
         rx_l_stage  <= '0;
         o_dac_l     <= '0;
         o_dac_r     <= '0;
         o_dac_valid <= 1'b0;
      end else begin
         o_dac_valid <= 1'b0;
         if (clear) begin
            rx_sh      <= '0;
            rx_l_stage <= '0;
         end else if (rise && (in_left(slot) || in_right(slot))) begin
            rx_sh <= rx_word[SAMPLE_W-2:0];
            if (slot == SLOT_L_LAST) begin
               rx_l_stage <= rx_word;
            end
            if (slot == SLOT_R_LAST) begin
               o_dac_l     <= rx_l_stage;
               o_dac_r     <= rx_word;
               o_dac_valid <= 1'b1;
            end
         end
      end
   end

endmodule

// File: tb/tb_aud_i2s_codec_master.sv
// Directed loopback bench for aud_i2s_codec_master with BCLK_HALF=2.
module tb_aud_i2s_codec_master;

   logic        clk = 1'b0;
   logic        rst_n;
   logic        en;
   logic [15:0] adc_l, adc_r;
   logic        adc_valid;
   logic        adc_ready;
   logic        underrun;
   logic [15:0] dac_l, dac_r;
   logic        dac_valid;
   logic        bclk, lrck, adcdat;
   logic        dacdat;

   int total = 0;
   int bad   = 0;

   // monitor state
   int          fallcnt = 0;
   int          cur_slot = 63;
   int          nvalid = 0;
   int          nunder = 0;
   logic        prev_bclk = 1'b0;
   logic [63:0] adc_rec [8];
   logic [63:0] lrck_rec [8];
   logic [15:0] dl_hist [32];
   logic [15:0] dr_hist [32];
   logic        align_ok [32];

   always #5 clk = ~clk;

   assign dacdat = adcdat;

   aud_i2s_codec_master #(
      .BCLK_HALF (2)
   ) dut (
      .i_clk       (clk),
      .i_rst_n     (rst_n),
      .i_en        (en),
      .i_adc_l     (adc_l),
      .i_adc_r     (adc_r),
      .i_adc_valid (adc_valid),
      .o_adc_ready (adc_ready),
      .o_underrun  (underrun),
      .o_dac_l     (dac_l),
      .o_dac_r     (dac_r),
      .o_dac_valid (dac_valid),
      .o_bclk      (bclk),
      .o_lrck      (lrck),
      .o_adcdat    (adcdat),
      .i_dacdat    (dacdat)
   );

   always @(negedge clk) begin
      if (!rst_n || !en) begin
         fallcnt  <= 0;
         cur_slot <= 63;
      end else if (prev_bclk && !bclk) begin
         cur_slot <= fallcnt % 64;
         if (fallcnt < 512) begin
            adc_rec[fallcnt / 64][fallcnt % 64]  <= adcdat;
            lrck_rec[fallcnt / 64][fallcnt % 64] <= lrck;
         end
         fallcnt <= fallcnt + 1;
      end
      if (dac_valid) begin
         if (nvalid < 32) begin
            dl_hist[nvalid]  <= dac_l;
            dr_hist[nvalid]  <= dac_r;
            align_ok[nvalid] <= bclk && !prev_bclk && (cur_slot == 48);
         end
         nvalid <= nvalid + 1;
      end
      if (underrun) nunder <= nunder + 1;
      prev_bclk <= rst_n ? bclk : 1'b0;
   end

   task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
      total++;
      if (got !== exp) begin
         bad++;
         $display("FAIL %s: got %h expected %h", tag, got, exp);
      end
   endtask

   task automatic step(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   task automatic wait_valid(input int target, input string tag);
      int n = 0;
      while (nvalid < target && n < 600) begin
         step(1);
         n++;
      end
      step(1);
      chk(tag, 64'(nvalid), 64'(target));
   endtask

   task automatic wait_slot(input int s, input bit need_bclk, input string tag);
      int n = 0;
      bit found = 0;
      while (!found && n < 600) begin
         if (cur_slot == s && (!need_bclk || bclk)) found = 1;
         else begin
            step(1);
            n++;
         end
      end
      chk(tag, 64'(found), 64'd1);
   endtask

   task automatic push(input logic [15:0] l, input logic [15:0] r);
      adc_l     = l;
      adc_r     = r;
      adc_valid = 1'b1;
      step(1);
      adc_valid = 1'b0;
   endtask

   int base_v, base_u, edges, n;
   bit rdy_before, accepted;

   initial begin
      rst_n = 1'b0;
      en = 1'b0;
      adc_l = '0;
      adc_r = '0;
      adc_valid = 1'b0;
      step(3);
      chk("rst_bclk", 64'(bclk), 64'd0);
      chk("rst_lrck", 64'(lrck), 64'd1);
      chk("rst_adcdat", 64'(adcdat), 64'd0);
      chk("rst_ready", 64'(adc_ready), 64'd1);
      chk("rst_dac", {32'h0, dac_l, dac_r}, 64'h0);
      chk("rst_pulses", {62'h0, dac_valid, underrun}, 64'h0);
      rst_n = 1'b1;
      step(2);

      // loopback: one pair, then an underrun frame
      push(16'hA5C3, 16'h0F0F);
      chk("lb_ready_full", 64'(adc_ready), 64'd0);
      base_v = nvalid;
      base_u = nunder;
      en = 1'b1;
      step(1);
      chk("start_c1_bclk", 64'(bclk), 64'd0);
      step(1);
      chk("start_c2_bclk", 64'(bclk), 64'd1);
      step(1);
      chk("start_c3_lrck", {62'h0, bclk, lrck}, 64'h3);
      step(1);
      chk("start_c4_fall", {62'h0, bclk, lrck}, 64'h0);
      chk("start_c4_nounder", 64'(underrun), 64'd0);
      chk("start_c4_ready", 64'(adc_ready), 64'd1);
      wait_valid(base_v + 1, "lb_f1_pulse");
      chk("lb_f1_data", {32'h0, dl_hist[base_v], dr_hist[base_v]}, 64'h0000_0000_A5C3_0F0F);
      chk("lb_f1_align", 64'(align_ok[base_v]), 64'd1);
      wait_valid(base_v + 2, "lb_f2_pulse");
      chk("lb_f2_data", {32'h0, dl_hist[base_v+1], dr_hist[base_v+1]}, 64'h0);
      chk("lb_f2_underrun", 64'(nunder - base_u), 64'd1);
      en = 1'b0;
      step(2);

      // slot mapping
      push(16'h8000, 16'h0001);
      base_v = nvalid;
      en = 1'b1;
      n = 0;
      while (fallcnt < 65 && n < 600) begin
         step(1);
         n++;
      end
      chk("map_adcdat", adc_rec[0], 64'h0001_0000_0000_0002);
      chk("map_lrck", lrck_rec[0], 64'hFFFF_FFFF_0000_0000);
      wait_valid(base_v + 1, "map_pulse");
      chk("map_data", {32'h0, dl_hist[base_v], dr_hist[base_v]}, 64'h0000_0000_8000_0001);
      en = 1'b0;
      step(2);

      // backpressure: P1 held, P2 waits for the first frame start
      push(16'h1111, 16'h2222);
      adc_l = 16'h3333;
      adc_r = 16'h4444;
      adc_valid = 1'b1;
      chk("bp_ready_full", 64'(adc_ready), 64'd0);
      base_v = nvalid;
      base_u = nunder;
      en = 1'b1;
      edges = 0;
      accepted = 0;
      while (!accepted && edges < 20) begin
         rdy_before = adc_ready;
         step(1);
         edges++;
         if (rdy_before) accepted = 1;
      end
      adc_valid = 1'b0;
      chk("bp_accept_edge", 64'(edges), 64'd5);
      wait_valid(base_v + 1, "bp_p1_pulse");
      chk("bp_p1_data", {32'h0, dl_hist[base_v], dr_hist[base_v]}, 64'h0000_0000_1111_2222);
      wait_valid(base_v + 2, "bp_p2_pulse");
      chk("bp_p2_data", {32'h0, dl_hist[base_v+1], dr_hist[base_v+1]}, 64'h0000_0000_3333_4444);
      chk("bp_no_underrun", 64'(nunder - base_u), 64'd0);

      // accept coinciding with an empty-holding frame start
      wait_slot(63, 1'b1, "sim_find_slot63");
      step(1);
      adc_l = 16'h5A5A;
      adc_r = 16'hC3C3;
      adc_valid = 1'b1;
      step(1);
      adc_valid = 1'b0;
      chk("sim_underrun", {61'h0, underrun, bclk, lrck}, 64'h4);
      chk("sim_ready", 64'(adc_ready), 64'd0);
      wait_valid(base_v + 3, "sim_zero_pulse");
      chk("sim_zero_data", {32'h0, dl_hist[base_v+2], dr_hist[base_v+2]}, 64'h0);
      wait_valid(base_v + 4, "sim_pair_pulse");
      chk("sim_pair_data", {32'h0, dl_hist[base_v+3], dr_hist[base_v+3]}, 64'h0000_0000_5A5A_C3C3);

      // drop enable mid-frame at slot 40
      wait_slot(40, 1'b0, "dis_find_slot40");
      en = 1'b0;
      step(1);
      chk("dis_idle_vals", {61'h0, bclk, lrck, adcdat}, 64'h2);
      base_v = nvalid;
      step(80);
      chk("dis_no_pulse", 64'(nvalid - base_v), 64'd0);
      chk("dis_dac_kept", {32'h0, dac_l, dac_r}, 64'h0000_0000_5A5A_C3C3);
      push(16'h1234, 16'hABCD);
      base_u = nunder;
      en = 1'b1;
      step(3);
      chk("re_c3", {62'h0, bclk, lrck}, 64'h3);
      step(1);
      chk("re_c4_fall", {62'h0, bclk, lrck}, 64'h0);
      wait_valid(base_v + 1, "re_pulse");
      chk("re_data", {32'h0, dl_hist[base_v], dr_hist[base_v]}, 64'h0000_0000_1234_ABCD);
      chk("re_align", 64'(align_ok[base_v]), 64'd1);
      chk("re_no_underrun", 64'(nunder - base_u), 64'd0);

      // asynchronous reset mid-frame
      push(16'h7777, 16'h8888);
      chk("ar_ready_full", 64'(adc_ready), 64'd0);
      step(20);
      #3;
      rst_n = 1'b0;
      #1;
      chk("ar_clk_outs", {61'h0, bclk, lrck, adcdat}, 64'h2);
      chk("ar_ready", 64'(adc_ready), 64'd1);
      chk("ar_dac", {32'h0, dac_l, dac_r}, 64'h0);
      chk("ar_pulses", {62'h0, dac_valid, underrun}, 64'h0);
      step(2);
      en = 1'b0;
      rst_n = 1'b1;
      step(2);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
